model_linear_controller_dot_product: RTL and testbench

//  Streaming signed dot product y = sum_{i<SIZE_IN} A[i]*B[i], one weight row by input vector.

---
 rtl/model_linear_controller_verilog_pkg.sv | 18 +
 rtl/model_dot_product_mac.sv | 52 +++++
 rtl/model_linear_controller_dot_product.sv | 139 +++++++++++++
 tb/tb_model_linear_controller_dot_product.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/model_linear_controller_verilog_pkg.sv
// Shared constants and state encoding for the linear-controller dot product.
// Word width, vector-length width and the FSM state type live here so the
// top module, the MAC and the bench all agree on them.
package model_linear_controller_verilog_pkg;

   localparam int DATA_SIZE    = 64;
   localparam int CONTROL_SIZE = 4;

   localparam logic [CONTROL_SIZE-1:0] ZERO_CONTROL = '0;
   localparam logic [CONTROL_SIZE-1:0] ONE_CONTROL  = CONTROL_SIZE'(1);

   typedef enum logic [1:0] {
      STARTER_STATE = 2'd0,
      INPUT_STATE   = 2'd1,
      ENDER_STATE   = 2'd2
   } state_t;

endpackage

// File: rtl/model_dot_product_mac.sv
// Combinational multiply-accumulate step: acc_out = acc_in + a*b.
// Build option MODEL_DOT_PRODUCT_SATURATE_EN: when defined, the product is
// clamped to the signed DATA_SIZE range and the sum saturates at MAX/MIN;
// when undefined, the low DATA_SIZE bits of the product are kept and the
// sum wraps modulo 2^DATA_SIZE.
module model_dot_product_mac
   import model_linear_controller_verilog_pkg::*;
(
   input  logic signed [DATA_SIZE-1:0] acc_in,
   input  logic signed [DATA_SIZE-1:0] a,
   input  logic signed [DATA_SIZE-1:0] b,
   output logic signed [DATA_SIZE-1:0] acc_out
);

`ifdef MODEL_DOT_PRODUCT_SATURATE_EN
   localparam logic signed [DATA_SIZE-1:0] WORD_MAX = {1'b0, {(DATA_SIZE-1){1'b1}}};
   localparam logic signed [DATA_SIZE-1:0] WORD_MIN = {1'b1, {(DATA_SIZE-1){1'b0}}};
   localparam logic signed [2*DATA_SIZE-1:0] PROD_MAX =
      {{(DATA_SIZE+1){1'b0}}, {(DATA_SIZE-1){1'b1}}};
   localparam logic signed [2*DATA_SIZE-1:0] PROD_MIN =
      {{(DATA_SIZE+1){1'b1}}, {(DATA_SIZE-1){1'b0}}};

   logic signed [2*DATA_SIZE-1:0] prod_full;
   logic signed [DATA_SIZE-1:0]   prod_sat;
   logic        [DATA_SIZE:0]     sum_ext;

   // Full-precision product, clamp it, then add with one guard bit and clamp again.
   always_comb begin
      prod_full = (2*DATA_SIZE)'(a) * (2*DATA_SIZE)'(b);
      if (prod_full > PROD_MAX) begin
         prod_sat = WORD_MAX;
      end else if (prod_full < PROD_MIN) begin
         prod_sat = WORD_MIN;
      end else begin
         prod_sat = prod_full[DATA_SIZE-1:0];
      end
      sum_ext = {acc_in[DATA_SIZE-1], acc_in} + {prod_sat[DATA_SIZE-1], prod_sat};
      if (sum_ext[DATA_SIZE] != sum_ext[DATA_SIZE-1]) begin
         acc_out = sum_ext[DATA_SIZE] ? WORD_MIN : WORD_MAX;
      end else begin
         acc_out = sum_ext[DATA_SIZE-1:0];
      end
   end
`else
   // Low word of the product equals the low word of the full signed product,
   // so a same-width multiply gives the wrap result directly.
   always_comb begin
      acc_out = acc_in + a * b;
   end
`endif

endmodule

// File: rtl/model_linear_controller_dot_product.sv
// Streaming signed dot product of one weight row with the input vector.
// START latches the vector length; operand elements of A and B arrive with
// independent enables, are parked in one-deep registers, and each complete
// pair is accumulated in the following cycle.  The result is registered
// into DATA_OUT together with a one-cycle READY pulse.
// Handshake: an A (or B) element is taken on a rising edge where
// DATA_ENABLE is high and DATA_x_IN_ENABLE is high and that operand's slot
// is empty; an enable while the slot is full, or while DATA_ENABLE is low,
// is dropped.
// Build option: MODEL_DOT_PRODUCT_SATURATE_EN selects saturating arithmetic
// in the MAC (see model_dot_product_mac).
module model_linear_controller_dot_product
   import model_linear_controller_verilog_pkg::*;
(
   input  logic                    CLK,
   input  logic                    RST,
   input  logic                    START,
   output logic                    READY,
   input  logic                    DATA_A_IN_ENABLE,
   input  logic                    DATA_B_IN_ENABLE,
   output logic                    DATA_ENABLE,
   input  logic [CONTROL_SIZE-1:0] SIZE_IN,
   input  logic [DATA_SIZE-1:0]    DATA_A_IN,
   input  logic [DATA_SIZE-1:0]    DATA_B_IN,
   output logic [DATA_SIZE-1:0]    DATA_OUT,
   output logic [1:0]              state_dbg
);

   state_t                      state;
   state_t                      state_next;
   logic [CONTROL_SIZE-1:0]     size_reg;
   logic [CONTROL_SIZE-1:0]     index;
   logic signed [DATA_SIZE-1:0] acc;
   logic signed [DATA_SIZE-1:0] a_reg;
   logic signed [DATA_SIZE-1:0] b_reg;
   logic                        a_valid;
   logic                        b_valid;
   logic                        pair_ready;
   logic                        last_pair;
   logic signed [DATA_SIZE-1:0] acc_next;

   assign pair_ready = a_valid && b_valid;
   assign last_pair  = (index == (size_reg - ONE_CONTROL));
   assign state_dbg  = state;

   model_dot_product_mac u_mac (
      .acc_in  (acc),
      .a       (a_reg),
      .b       (b_reg),
      .acc_out (acc_next)
   );

   // State register.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state <= STARTER_STATE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state decode and the operand-accept strobe.
   always_comb begin
      state_next  = state;
      DATA_ENABLE = 1'b0;
      case (state)
         STARTER_STATE: begin
            if (START) begin
               state_next = (SIZE_IN == ZERO_CONTROL) ? ENDER_STATE : INPUT_STATE;
            end
         end
         INPUT_STATE: begin
            DATA_ENABLE = !pair_ready;
            if (pair_ready && last_pair) begin
               state_next = ENDER_STATE;
            end
         end
         ENDER_STATE: begin
            state_next = STARTER_STATE;
         end
         default: begin
            state_next = STARTER_STATE;
         end
      endcase
   end

   // Datapath: operand capture, accumulation, index count and result register.
   always_ff @(posedge CLK) begin
      if (RST) begin
         size_reg <= ZERO_CONTROL;
         index    <= ZERO_CONTROL;
         acc      <= '0;
         a_reg    <= '0;
         b_reg    <= '0;
         a_valid  <= 1'b0;
         b_valid  <= 1'b0;
         DATA_OUT <= '0;
         READY    <= 1'b0;
      end else begin
         READY <= 1'b0;
         case (state)
            STARTER_STATE: begin
               if (START) begin
                  size_reg <= SIZE_IN;
                  index    <= ZERO_CONTROL;
                  acc      <= '0;
                  a_valid  <= 1'b0;
                  b_valid  <= 1'b0;
               end
            end
            INPUT_STATE: begin
               if (pair_ready) begin
                  acc     <= acc_next;
                  a_valid <= 1'b0;
                  b_valid <= 1'b0;
                  index   <= index + ONE_CONTROL;
               end else begin
                  if (DATA_A_IN_ENABLE && !a_valid) begin
                     a_reg   <= DATA_A_IN;
                     a_valid <= 1'b1;
                  end
                  if (DATA_B_IN_ENABLE && !b_valid) begin
                     b_reg   <= DATA_B_IN;
                     b_valid <= 1'b1;
                  end
               end
            end
            ENDER_STATE: begin
               DATA_OUT <= acc;
               READY    <= 1'b1;
            end
            default: begin
               READY <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_model_linear_controller_dot_product.sv
// Bench for model_linear_controller_dot_product: directed scenarios plus
// randomized vectors checked against an arithmetic reference model.
module tb_model_linear_controller_dot_product;
   import model_linear_controller_verilog_pkg::*;

   logic                    CLK = 1'b0;
   logic                    RST = 1'b1;
   logic                    START = 1'b0;
   logic                    READY;
   logic                    DATA_A_IN_ENABLE = 1'b0;
   logic                    DATA_B_IN_ENABLE = 1'b0;
   logic                    DATA_ENABLE;
   logic [CONTROL_SIZE-1:0] SIZE_IN = '0;
   logic [DATA_SIZE-1:0]    DATA_A_IN = '0;
   logic [DATA_SIZE-1:0]    DATA_B_IN = '0;
   logic [DATA_SIZE-1:0]    DATA_OUT;
   logic [1:0]              state_dbg;

   int n_checks = 0;
   int n_fail   = 0;

   logic signed [DATA_SIZE-1:0] va [16];
   logic signed [DATA_SIZE-1:0] vb [16];
   logic [DATA_SIZE-1:0]        exp_q [$];

   localparam logic signed [127:0] MAX128 = (128'sd1 <<< 63) - 128'sd1;
   localparam logic signed [127:0] MIN128 = -(128'sd1 <<< 63);

   model_linear_controller_dot_product dut (
      .CLK              (CLK),
      .RST              (RST),
      .START            (START),
      .READY            (READY),
      .DATA_A_IN_ENABLE (DATA_A_IN_ENABLE),
      .DATA_B_IN_ENABLE (DATA_B_IN_ENABLE),
      .DATA_ENABLE      (DATA_ENABLE),
      .SIZE_IN          (SIZE_IN),
      .DATA_A_IN        (DATA_A_IN),
      .DATA_B_IN        (DATA_B_IN),
      .DATA_OUT         (DATA_OUT),
      .state_dbg        (state_dbg)
   );

   // Clock.
   always #5 CLK = ~CLK;

   // Reference: sum of products over the first n elements in wide arithmetic.
   function automatic logic [DATA_SIZE-1:0] ref_dot(input int n);
      logic signed [127:0] s;
      logic signed [127:0] p;
      s = '0;
      for (int i = 0; i < n; i++) begin
         p = 128'(va[i]) * 128'(vb[i]);
`ifdef MODEL_DOT_PRODUCT_SATURATE_EN
         if (p > MAX128) p = MAX128;
         if (p < MIN128) p = MIN128;
         s = s + p;
         if (s > MAX128) s = MAX128;
         if (s < MIN128) s = MIN128;
`else
         s = s + p;
`endif
      end
      return s[DATA_SIZE-1:0];
   endfunction

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic pulse_start(input int n);
      START   = 1'b1;
      SIZE_IN = CONTROL_SIZE'(n);
      tick();
      START   = 1'b0;
   endtask

   // Bounded wait for the block to accept operands.
   task automatic wait_enable();
      int seen;
      seen = 0;
      for (int c = 0; c < 20; c++) begin
         if (DATA_ENABLE === 1'b1) begin
            seen = 1;
            break;
         end
         tick();
      end
      n_checks++;
      if (seen == 0) begin
         n_fail++;
         $display("FAIL wait_enable: DATA_ENABLE=%b required 1 within 20 cycles", DATA_ENABLE);
      end
   endtask

   // Drive n pairs. mode 0: A and B together; 1: B three cycles after A; 2: random offsets.
   task automatic feed(input int n, input int mode);
      int da;
      int db;
      int last;
      for (int i = 0; i < n; i++) begin
         wait_enable();
         if (mode == 1) begin
            da = 0;
            db = 3;
         end else if (mode == 2) begin
            da = $urandom_range(0, 3);
            db = $urandom_range(0, 3);
         end else begin
            da = 0;
            db = 0;
         end
         last = (da > db) ? da : db;
         for (int t = 0; t <= last; t++) begin
            if (t > 0) begin
               n_checks++;
               if (DATA_ENABLE !== 1'b1) begin
                  n_fail++;
                  $display("FAIL de_waiting: DATA_ENABLE=%b required 1 (elem %0d slot %0d)", DATA_ENABLE, i, t);
               end
            end
            DATA_A_IN_ENABLE = (t == da);
            DATA_B_IN_ENABLE = (t == db);
            DATA_A_IN        = (t == da) ? va[i] : $urandom;
            DATA_B_IN        = (t == db) ? vb[i] : $urandom;
            tick();
            DATA_A_IN_ENABLE = 1'b0;
            DATA_B_IN_ENABLE = 1'b0;
         end
         n_checks++;
         if (DATA_ENABLE !== 1'b0) begin
            n_fail++;
            $display("FAIL de_accumulate: DATA_ENABLE=%b required 0 (elem %0d)", DATA_ENABLE, i);
         end
      end
   endtask

   // Scoreboard: wait for READY, compare DATA_OUT with the queued value, check single pulse and hold.
   task automatic expect_result(input string name);
      logic [DATA_SIZE-1:0] exp;
      int got;
      got = 0;
      exp = exp_q.pop_front();
      for (int c = 0; c < 10; c++) begin
         if (READY === 1'b1) begin
            got = 1;
            break;
         end
         tick();
      end
      n_checks++;
      if (got == 0) begin
         n_fail++;
         $display("FAIL %s_ready: READY=%b required 1 within 10 cycles", name, READY);
         return;
      end
      n_checks++;
      if (DATA_OUT !== exp) begin
         n_fail++;
         $display("FAIL %s_data: DATA_OUT=%0d required %0d", name, $signed(DATA_OUT), $signed(exp));
      end
      for (int c = 0; c < 3; c++) begin
         tick();
         n_checks++;
         if (READY !== 1'b0 || DATA_OUT !== exp) begin
            n_fail++;
            $display("FAIL %s_hold: READY=%b DATA_OUT=%0d required READY=0 DATA_OUT=%0d",
                     name, READY, $signed(DATA_OUT), $signed(exp));
         end
      end
   endtask

   task automatic test_reset();
      RST = 1'b1;
      repeat (3) tick();
      n_checks++;
      if (READY !== 1'b0 || DATA_ENABLE !== 1'b0 || DATA_OUT !== '0 || state_dbg !== 2'd0) begin
         n_fail++;
         $display("FAIL reset: READY=%b DATA_ENABLE=%b DATA_OUT=%0h state=%0d required 0/0/0/0",
                  READY, DATA_ENABLE, DATA_OUT, state_dbg);
      end
      RST = 1'b0;
      tick();
   endtask

   task automatic test_basic();
      va[0] = 1; va[1] = 2; va[2] = 3;
      vb[0] = 4; vb[1] = 5; vb[2] = 6;
      exp_q.push_back(64'd32);
      pulse_start(3);
      feed(3, 0);
      expect_result("basic");
   endtask

   task automatic test_size_zero();
      int de_seen;
      de_seen = 0;
      pulse_start(0);
      de_seen = de_seen | int'(DATA_ENABLE);
      n_checks++;
      if (READY !== 1'b0) begin
         n_fail++;
         $display("FAIL zero_early: READY=%b required 0 one cycle after START", READY);
      end
      tick();
      de_seen = de_seen | int'(DATA_ENABLE);
      n_checks++;
      if (READY !== 1'b1 || DATA_OUT !== '0) begin
         n_fail++;
         $display("FAIL zero_ready: READY=%b DATA_OUT=%0d required 1/0 two cycles after START",
                  READY, $signed(DATA_OUT));
      end
      tick();
      de_seen = de_seen | int'(DATA_ENABLE);
      n_checks++;
      if (READY !== 1'b0 || de_seen != 0) begin
         n_fail++;
         $display("FAIL zero_after: READY=%b de_seen=%0d required 0/0", READY, de_seen);
      end
   endtask

   task automatic test_late_b();
      va[0] = -3; va[1] = 7;
      vb[0] = 5;  vb[1] = 2;
      exp_q.push_back(-64'sd1);
      pulse_start(2);
      feed(2, 1);
      expect_result("late_b");
   endtask

   task automatic test_saturate();
      va[0] = 64'sd1 <<< 62; va[1] = 64'sd1 <<< 62;
      vb[0] = 2;             vb[1] = 2;
`ifdef MODEL_DOT_PRODUCT_SATURATE_EN
      exp_q.push_back(64'h7fff_ffff_ffff_ffff);
`else
      exp_q.push_back(64'd0);
`endif
      pulse_start(2);
      feed(2, 0);
      expect_result("saturate");
   endtask

   task automatic test_double_a();
      exp_q.push_back(64'd18);
      pulse_start(1);
      DATA_A_IN_ENABLE = 1'b1; DATA_A_IN = 64'd9;
      tick();
      DATA_A_IN = 64'd8;
      tick();
      DATA_A_IN_ENABLE = 1'b0;
      n_checks++;
      if (DATA_ENABLE !== 1'b1) begin
         n_fail++;
         $display("FAIL double_a_wait: DATA_ENABLE=%b required 1", DATA_ENABLE);
      end
      pulse_start(7);
      DATA_B_IN_ENABLE = 1'b1; DATA_B_IN = 64'd2;
      tick();
      DATA_B_IN_ENABLE = 1'b0;
      expect_result("double_a");
      n_checks++;
      if (state_dbg !== 2'd0) begin
         n_fail++;
         $display("FAIL double_a_idle: state=%0d required 0", state_dbg);
      end
   endtask

   task automatic test_reset_mid();
      int ready_seen;
      ready_seen = 0;
      va[0] = 11; va[1] = 12; va[2] = 13;
      vb[0] = 3;  vb[1] = 4;  vb[2] = 5;
      pulse_start(3);
      feed(1, 0);
      tick();
      RST = 1'b1;
      tick();
      RST = 1'b0;
      for (int c = 0; c < 8; c++) begin
         ready_seen = ready_seen | int'(READY);
         n_checks++;
         if (DATA_OUT !== '0 || DATA_ENABLE !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_state: DATA_OUT=%0d DATA_ENABLE=%b required 0/0",
                     $signed(DATA_OUT), DATA_ENABLE);
         end
         tick();
      end
      n_checks++;
      if (ready_seen != 0) begin
         n_fail++;
         $display("FAIL reset_mid_ready: ready_seen=%0d required 0", ready_seen);
      end
      va[0] = 5; vb[0] = 5;
      exp_q.push_back(64'd25);
      pulse_start(1);
      feed(1, 0);
      expect_result("after_reset");
   endtask

   task automatic test_random();
      int n;
      for (int r = 0; r < 8; r++) begin
         n = $urandom_range(1, 15);
         for (int i = 0; i < n; i++) begin
            if (r[0]) begin
               va[i] = {$urandom, $urandom};
               vb[i] = {$urandom, $urandom};
            end else begin
               va[i] = 64'($urandom_range(0, 2000)) - 64'd1000;
               vb[i] = 64'($urandom_range(0, 2000)) - 64'd1000;
            end
         end
         exp_q.push_back(ref_dot(n));
         pulse_start(n);
         feed(n, 2);
         expect_result($sformatf("random%0d", r));
      end
   endtask

   initial begin
      tick();
      test_reset();
      test_basic();
      test_size_zero();
      test_late_b();
      test_saturate();
      test_double_a();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
